vend_dispenser: RTL



---
 rtl/vend_pkg.sv | 22 ++
 rtl/pend_counter.sv | 37 +++
 rtl/vend_dispenser.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending back-end dispenser.
// Holds the actuation state encoding and the default timeouts.
package vend_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StCan,
      StChange,
      StFault
   } state_e;

   localparam int unsigned MotorTimeoutDef  = 16;
   localparam int unsigned HopperTimeoutDef = 8;

   // Timer counts 0..timeout-1, so clog2 of the larger timeout is enough.
   function automatic int unsigned timer_w(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return ($clog2(m) < 1) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/pend_counter.sv
// Saturating up/down request counter with a sticky overflow flag.
// Simultaneous increment and decrement leave the count unchanged.
module pend_counter #(
   parameter int unsigned PEND_W = 3
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_inc,
   input  logic              i_dec,
   output logic [PEND_W-1:0] o_count,
   output logic              o_overflow
);

   localparam logic [PEND_W-1:0] MaxCount = '1;

   logic [PEND_W-1:0] r_count;
   logic              r_overflow;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (i_inc && !i_dec) begin
         if (r_count == MaxCount) begin
            r_overflow <= 1'b1;
         end else begin
            r_count <= r_count + PEND_W'(1);
         end
      end else if (i_dec && !i_inc && (r_count != '0)) begin
         r_count <= r_count - PEND_W'(1);
      end
   end

   assign o_count    = r_count;
   assign o_overflow = r_overflow;

endmodule

// File: rtl/vend_dispenser.sv
// Closed-loop actuator sequencer: drives the can motor and change hopper until
// the matching sensor confirms delivery, faulting on timeout; requests queue up.
module vend_dispenser
   import vend_pkg::*;
#(
   parameter int unsigned MOTOR_TIMEOUT  = MotorTimeoutDef,
   parameter int unsigned HOPPER_TIMEOUT = HopperTimeoutDef,
   parameter int unsigned PEND_W         = 3
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_can_out,
   input  logic              i_change_out,
   input  logic              i_can_sensor,
   input  logic              i_coin_sensor,
   input  logic              i_fault_clr,
   output logic              o_motor_en,
   output logic              o_hopper_en,
   output logic              o_busy,
   output logic              o_fault,
   output logic              o_overflow,
   output logic [PEND_W-1:0] o_pend_cans,
   output logic [PEND_W-1:0] o_pend_change
);

   localparam int unsigned       TimerW     = timer_w(MOTOR_TIMEOUT, HOPPER_TIMEOUT);
   localparam logic [TimerW-1:0] MotorLast  = TimerW'(MOTOR_TIMEOUT - 1);
   localparam logic [TimerW-1:0] HopperLast = TimerW'(HOPPER_TIMEOUT - 1);

   state_e            r_state;
   logic [TimerW-1:0] r_timer;
   logic              r_motor_en;
   logic              r_hopper_en;
   logic              r_busy;
   logic              r_fault;

   logic              w_can_done;
   logic              w_coin_done;
   logic [PEND_W-1:0] w_pend_cans;
   logic [PEND_W-1:0] w_pend_change;
   logic              w_ovf_cans;
   logic              w_ovf_change;

   // Sensor pulses only count while the matching actuator is being driven.
   assign w_can_done  = (r_state == StCan) && i_can_sensor;
   assign w_coin_done = (r_state == StChange) && i_coin_sensor;

   pend_counter #(
      .PEND_W (PEND_W)
   ) u_pend_cans (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_inc      (i_can_out),
      .i_dec      (w_can_done),
      .o_count    (w_pend_cans),
      .o_overflow (w_ovf_cans)
   );

   pend_counter #(
      .PEND_W (PEND_W)
   ) u_pend_change (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_inc      (i_change_out),
      .i_dec      (w_coin_done),
      .o_count    (w_pend_change),
      .o_overflow (w_ovf_change)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= StIdle;
         r_timer     <= '0;
         r_motor_en  <= 1'b0;
         r_hopper_en <= 1'b0;
         r_busy      <= 1'b0;
         r_fault     <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               r_timer <= '0;
               if (w_pend_cans != '0) begin
                  r_state    <= StCan;
                  r_motor_en <= 1'b1;
                  r_busy     <= 1'b1;
               end else if (w_pend_change != '0) begin
                  r_state     <= StChange;
                  r_hopper_en <= 1'b1;
                  r_busy      <= 1'b1;
               end
            end
            StCan: begin
               if (i_can_sensor) begin
                  r_state    <= StIdle;
                  r_timer    <= '0;
                  r_motor_en <= 1'b0;
                  r_busy     <= 1'b0;
               end else if (r_timer == MotorLast) begin
                  r_state    <= StFault;
                  r_timer    <= '0;
                  r_motor_en <= 1'b0;
                  r_fault    <= 1'b1;
               end else begin
                  r_timer <= r_timer + TimerW'(1);
               end
            end
            StChange: begin
               if (i_coin_sensor) begin
                  r_state     <= StIdle;
                  r_timer     <= '0;
                  r_hopper_en <= 1'b0;
                  r_busy      <= 1'b0;
               end else if (r_timer == HopperLast) begin
                  r_state     <= StFault;
                  r_timer     <= '0;
                  r_hopper_en <= 1'b0;
                  r_fault     <= 1'b1;
               end else begin
                  r_timer <= r_timer + TimerW'(1);
               end
            end
            StFault: begin
               // Counter is left intact so IDLE re-dispatches the failed item.
               if (i_fault_clr) begin
                  r_state <= StIdle;
                  r_timer <= '0;
                  r_fault <= 1'b0;
                  r_busy  <= 1'b0;
               end
            end
         endcase
      end
   end

   assign o_motor_en    = r_motor_en;
   assign o_hopper_en   = r_hopper_en;
   assign o_busy        = r_busy;
   assign o_fault       = r_fault;
   assign o_overflow    = w_ovf_cans | w_ovf_change;
   assign o_pend_cans   = w_pend_cans;
   assign o_pend_change = w_pend_change;

endmodule
